// File: rtl/cordic_result_serializer_if.sv
// Result/byte-stream bundle between the CORDIC engine, the serializer and the byte sink.
// master = serializer side, slave = engine/sink side.
interface cordic_result_serializer_if #(
    parameter int DATA_WIDTH = 18,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic signed [DATA_WIDTH-1:0] in_costheta;
    logic signed [DATA_WIDTH-1:0] in_sintheta;
    logic signed [DATA_WIDTH-1:0] in_alpha;
    logic                         i_valid_in;
    logic [7:0]                   o_byte;
    logic                         o_byte_valid;
    logic                         i_byte_ready;
    logic                         o_last;
    logic                         o_overflow;
    logic                         i_ovf_clr;
    logic [LVL_W-1:0]             o_fifo_level;

    modport master (
        input  in_costheta, in_sintheta, in_alpha, i_valid_in, i_byte_ready, i_ovf_clr,
        output o_byte, o_byte_valid, o_last, o_overflow, o_fifo_level
    );

    modport slave (
        output in_costheta, in_sintheta, in_alpha, i_valid_in, i_byte_ready, i_ovf_clr,
        input  o_byte, o_byte_valid, o_last, o_overflow, o_fifo_level
    );
endinterface

// File: rtl/cordic_result_serializer.sv
// Buffers CORDIC {cos, sin[, alpha]} results in a frame FIFO and streams them MSB-first as bytes.
// Optional feature macro: CORDIC_SER_ALPHA_EN (adds the residual angle to every frame).
module cordic_result_serializer #(
    parameter int DATA_WIDTH = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    cordic_result_serializer_if.master ser
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef CORDIC_SER_ALPHA_EN
    localparam int WORDS = 3;
`else
    localparam int WORDS = 2;
`endif
    localparam int FRAME_BYTES = 3 * WORDS;
    localparam int FRAME_BITS  = 24 * WORDS;
    localparam int ENTRY_W     = DATA_WIDTH * WORDS;
    localparam int CW          = 4;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  ovf_q, ovf_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;

    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]    entry_in;
    logic [ENTRY_W-1:0]    head;
    logic [FRAME_BITS-1:0] frame_load;

    logic full, empty, push, drop, xfer, frame_done, pop;

    function automatic logic [23:0] sext24(input logic [DATA_WIDTH-1:0] w);
        logic [23:0] r;
        r = {24{w[DATA_WIDTH-1]}};
        r[DATA_WIDTH-1:0] = w;
        return r;
    endfunction

    // cos occupies the most significant word so it leaves the shift register first
`ifdef CORDIC_SER_ALPHA_EN
    assign entry_in = {ser.in_costheta, ser.in_sintheta, ser.in_alpha};
`else
    assign entry_in = {ser.in_costheta, ser.in_sintheta};
`endif

    assign head = fifo_mem[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign frame_load[FRAME_BITS-1-24*gi -: 24] =
                sext24(head[ENTRY_W-1-DATA_WIDTH*gi -: DATA_WIDTH]);
        end
    endgenerate

    // Full/empty come from the registered level, so a pop never makes room for a same-cycle push
    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign empty      = (level_q == '0);
    assign push       = ser.i_valid_in && !full;
    assign drop       = ser.i_valid_in && full;
    assign xfer       = (state_q == SEND) && ser.i_byte_ready;
    assign frame_done = xfer && (cnt_q == CW'(FRAME_BYTES - 1));
    assign pop        = !empty && ((state_q == IDLE) || frame_done);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (pop) begin
            shift_d  = frame_load;
            cnt_d    = '0;
            state_d  = SEND;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (frame_done) begin
            shift_d = shift_q << 8;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (xfer) begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q + 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        level_d = level_q + LW'(push) - LW'(pop);
        last_d  = (state_d == SEND) && (cnt_d == CW'(FRAME_BYTES - 1));
        ovf_d   = drop || (ovf_q && !ser.i_ovf_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Frame storage carries no reset; validity is tracked by the pointers and level
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= entry_in;
        end
    end

    assign ser.o_byte       = shift_q[FRAME_BITS-1 -: 8];
    assign ser.o_byte_valid = (state_q == SEND);
    assign ser.o_last       = last_q;
    assign ser.o_overflow   = ovf_q;
    assign ser.o_fifo_level = level_q;
endmodule

// File: tb/tb_cordic_result_serializer.sv
// Scoreboard bench for cordic_result_serializer: stimulus queues expected bytes, a negedge monitor checks them.
module tb_cordic_result_serializer;
    localparam int DW    = 18;
    localparam int DEPTH = 4;
`ifdef CORDIC_SER_ALPHA_EN
    localparam int FB = 9;
`else
    localparam int FB = 6;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cordic_result_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) ser ();

    cordic_result_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .ser     (ser)
    );

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q [$];   // {last, byte}
    logic       hold_pend = 1'b0;
    logic [7:0] hold_byte = 8'h00;
    logic [8:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [23:0] sx(input logic [DW-1:0] w);
        return 24'($signed(w));
    endfunction

    task automatic expect_frame(input logic [DW-1:0] c, input logic [DW-1:0] s, input logic [DW-1:0] a);
        logic [23:0] w [3];
        logic [23:0] x;
        logic [7:0]  b;
        w[0] = sx(c);
        w[1] = sx(s);
        w[2] = sx(a);
        for (int k = 0; k < FB; k++) begin
            x = w[k / 3];
            b = x[23 - 8 * (k % 3) -: 8];
            exp_q.push_back({(k == FB - 1), b});
        end
    endtask

    task automatic expect_bytes(input logic [7:0] b [9]);
        for (int k = 0; k < FB; k++) exp_q.push_back({(k == FB - 1), b[k]});
    endtask

    task automatic drive(input logic [DW-1:0] c, input logic [DW-1:0] s, input logic [DW-1:0] a);
        ser.in_costheta = c;
        ser.in_sintheta = s;
        ser.in_alpha    = a;
        ser.i_valid_in  = 1'b1;
        @(posedge clk); #1;
        ser.i_valid_in  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ser.o_byte_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: one line per accepted byte; also checks the byte holds while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else if (ser.o_byte_valid) begin
            if (hold_pend) check("hold_stable", ser.o_byte, hold_byte);
            if (ser.i_byte_ready) begin
                hold_pend = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %02h want none", ser.o_byte);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("xfer byte=%02h last=%0b (want %02h last=%0b)",
                             ser.o_byte, ser.o_last, mon_e[7:0], mon_e[8]);
                    check("byte", {ser.o_last, ser.o_byte}, mon_e);
                end
            end else begin
                hold_pend = 1'b1;
                hold_byte = ser.o_byte;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    logic [7:0] t1 [9] = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h32, 8'h44};
    logic [7:0] t2 [9] = '{8'hFF, 8'hC0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic [3:0] bp_pat = 4'b1001;   // ready sequence 1,0,0,1 (bit 0 first)

    initial begin
        int  n;
        logic seen;
        ser.in_costheta  = '0;
        ser.in_sintheta  = '0;
        ser.in_alpha     = '0;
        ser.i_valid_in   = 1'b0;
        ser.i_byte_ready = 1'b1;
        ser.i_ovf_clr    = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", ser.o_byte_valid, 0);
        check("rst_byte",  ser.o_byte, 0);
        check("rst_last",  ser.o_last, 0);
        check("rst_ovf",   ser.o_overflow, 0);
        check("rst_level", ser.o_fifo_level, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame and first-byte latency
        expect_bytes(t1);
        drive(18'h04000, 18'h00000, 18'h03244);
        check("lat_edge_k",  ser.o_byte_valid, 0);
        check("lat_level",   ser.o_fifo_level, 1);
        @(posedge clk); #1;
        check("lat_edge_k1", ser.o_byte_valid, 1);
        wait_drain("drain_basic");

        // Negative sign extension
        expect_bytes(t2);
        drive(18'h3C000, 18'h3FFFF, 18'h00000);
        wait_drain("drain_neg");

        // Backpressure
        expect_frame(18'h12345, 18'h2ABCD, 18'h00FFF);
        drive(18'h12345, 18'h2ABCD, 18'h00FFF);
        for (int i = 0; i < 40; i++) begin
            ser.i_byte_ready = bp_pat[i % 4];
            @(posedge clk); #1;
        end
        ser.i_byte_ready = 1'b1;
        wait_drain("drain_bp");

        // Burst with overflow
        ser.i_byte_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ser.in_costheta = DW'(32'h01010 * (i + 1));
            ser.in_sintheta = 18'h3FF00 | DW'(i);
            ser.in_alpha    = DW'(32'h00111 * (i + 2));
            ser.i_valid_in  = 1'b1;
            if (i < 5) expect_frame(ser.in_costheta, ser.in_sintheta, ser.in_alpha);
            @(posedge clk); #1;
        end
        ser.i_valid_in = 1'b0;
        check("burst_level", ser.o_fifo_level, 4);
        check("burst_ovf",   ser.o_overflow, 1);
        check("burst_valid", ser.o_byte_valid, 1);
        ser.i_ovf_clr = 1'b1;
        @(posedge clk); #1;
        ser.i_ovf_clr = 1'b0;
        check("ovf_clr", ser.o_overflow, 0);
        ser.in_costheta = 18'h1FFFF;
        ser.i_valid_in  = 1'b1;
        ser.i_ovf_clr   = 1'b1;
        @(posedge clk); #1;
        ser.i_valid_in  = 1'b0;
        ser.i_ovf_clr   = 1'b0;
        check("ovf_set_wins", ser.o_overflow, 1);
        check("drop_level",   ser.o_fifo_level, 4);
        ser.i_byte_ready = 1'b1;
        wait_drain("drain_burst");
        check("burst_empty", ser.o_fifo_level, 0);

        // Back-to-back frames
        ser.i_byte_ready = 1'b0;
        expect_frame(18'h0ABCD, 18'h30001, 18'h00042);
        drive(18'h0ABCD, 18'h30001, 18'h00042);
        expect_frame(18'h20000, 18'h1FFFF, 18'h3FFFE);
        drive(18'h20000, 18'h1FFFF, 18'h3FFFE);
        @(posedge clk); #1;
        check("b2b_level", ser.o_fifo_level, 1);
        ser.i_byte_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ser.o_byte_valid) n++;
            else break;
        end
        check("b2b_valid_run", n, 2 * FB);
        wait_drain("drain_b2b");

        // Reset mid-frame (overflow is still set from the burst test)
        expect_frame(18'h11111, 18'h22222, 18'h33333);
        drive(18'h11111, 18'h22222, 18'h33333);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ser.o_byte_valid, 0);
        check("mid_rst_byte",  ser.o_byte, 0);
        check("mid_rst_last",  ser.o_last, 0);
        check("mid_rst_ovf",   ser.o_overflow, 0);
        check("mid_rst_level", ser.o_fifo_level, 0);
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ser.o_byte_valid) seen = 1'b1;
        end
        check("no_residual", seen, 0);
        @(posedge clk); #1;
        expect_frame(18'h01234, 18'h3EDCB, 18'h00777);
        drive(18'h01234, 18'h3EDCB, 18'h00777);
        wait_drain("drain_recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
